// File: rtl/fpu_lib.sv
// rtl/fpu_lib.sv - shared FPU types and constants for the add/sub arbiter slice
package fpu_lib;

    localparam int FPU_ARB_MAX_NREQ = 8;

    typedef logic [15:0] fp16_t;

    typedef struct packed {
        logic z;
        logic c;
        logic n;
        logic v;
    } condCode_t;

    typedef struct packed {
        logic invalid;
        logic overflow;
        logic underflow;
        logic inexact;
    } opStatusFlag_t;

    typedef logic [$clog2(FPU_ARB_MAX_NREQ)-1:0] arbReqId_t;

    localparam fp16_t FP16_QNAN = 16'h7E00;

endpackage

// File: rtl/fpu_addsub16.sv
// rtl/fpu_addsub16.sv - combinational fp16 add/sub, truncating, subnormals flushed to zero
module fpuAddSub16
    import fpu_lib::*;
(
    input  fp16_t         in1,
    input  fp16_t         in2,
    input  logic          sub,
    output fp16_t         result,
    output condCode_t     condCodes,
    output opStatusFlag_t status
);

    logic              sA, sB, sL, sS, effSub, sticky, finite;
    logic [4:0]        eA, eB, eL, eS, d, p;
    logic [10:0]       mA, mB, mL, mS;
    logic [14:0]       magA, magB;
    logic              nanA, nanB, infA, infB;
    logic [21:0]       frameS, alignS, normFrac;
    logic [22:0]       sum;
    logic signed [6:0] eR;

    always_comb begin
        sA   = in1[15];
        sB   = in2[15] ^ sub;
        eA   = in1[14:10];
        eB   = in2[14:10];
        mA   = (eA == 5'd0) ? 11'd0 : {1'b1, in1[9:0]};
        mB   = (eB == 5'd0) ? 11'd0 : {1'b1, in2[9:0]};
        magA = (eA == 5'd0) ? 15'd0 : in1[14:0];
        magB = (eB == 5'd0) ? 15'd0 : in2[14:0];
        nanA = (eA == 5'h1f) && (in1[9:0] != 10'd0);
        nanB = (eB == 5'h1f) && (in2[9:0] != 10'd0);
        infA = (eA == 5'h1f) && (in1[9:0] == 10'd0);
        infB = (eB == 5'h1f) && (in2[9:0] == 10'd0);
        finite = !(nanA || nanB || infA || infB);

        if (magB > magA) begin
            sL = sB; eL = eB; mL = mB; sS = sA; eS = eA; mS = mA;
        end else begin
            sL = sA; eL = eA; mL = mA; sS = sB; eS = eB; mS = mB;
        end
        effSub = sL ^ sS;

        // Bits shifted past the frame borrow one unit so truncation of a difference stays exact
        d      = eL - eS;
        frameS = {mS, 11'd0};
        alignS = frameS >> d;
        sticky = (alignS << d) != frameS;
        sum    = effSub ? ({1'b0, mL, 11'd0} - {1'b0, alignS} - 23'(sticky))
                        : ({1'b0, mL, 11'd0} + {1'b0, alignS});

        p = 5'd0;
        for (int i = 0; i < 23; i++) begin
            if (sum[i]) p = 5'(i);
        end
        normFrac = 22'(sum << (5'd22 - p));
        eR       = $signed({2'b00, eL}) + $signed({2'b00, p}) - 7'sd21;

        result = '0;
        status = '0;
        if (nanA || nanB || (infA && infB && effSub)) begin
            result         = FP16_QNAN;
            status.invalid = 1'b1;
        end else if (infA || infB) begin
            result = {sL, 5'h1f, 10'd0};
        end else if (sum == 23'd0) begin
            result = '0;
        end else if (eR >= 7'sd31) begin
            result           = {sL, 5'h1f, 10'd0};
            status.overflow  = 1'b1;
            status.inexact   = 1'b1;
        end else if (eR <= 7'sd0) begin
            result           = {sL, 15'd0};
            status.underflow = 1'b1;
            status.inexact   = 1'b1;
        end else begin
            result         = {sL, eR[4:0], normFrac[21:12]};
            status.inexact = sticky || (normFrac[11:0] != 12'd0);
        end

        condCodes.z = (result[14:0] == 15'd0);
        condCodes.c = finite && sum[22];
        condCodes.n = result[15];
        condCodes.v = status.overflow;
    end

endmodule

// File: rtl/fpu_addsub_arbiter_picker.sv
// rtl/fpu_addsub_arbiter_picker.sv - rotate-priority one-hot picker starting at ptr
module fpuRRPicker #(
    parameter  int N  = 4,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  valid,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] index
);

    logic found;

    always_comb begin
        grant = '0;
        index = '0;
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!found && valid[(int'(ptr) + k) % N]) begin
                found                     = 1'b1;
                grant[(int'(ptr) + k) % N] = 1'b1;
                index                     = IW'((int'(ptr) + k) % N);
            end
        end
    end

endmodule

// File: rtl/fpu_addsub_arbiter.sv
// rtl/fpu_addsub_arbiter.sv - round-robin share of one fpuAddSub16 among NREQ requesters
// Optional FPU_ARB_STATS_EN adds saturating statBusy/statStall counters.
module fpu_addsub_arbiter
    import fpu_lib::*;
#(
    parameter  int NREQ = 4,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [NREQ-1:0]       reqValid,
    output logic [NREQ-1:0]       reqReady,
    input  logic [NREQ-1:0]       reqSub,
    input  fp16_t [NREQ-1:0]      reqIn1,
    input  fp16_t [NREQ-1:0]      reqIn2,
    output logic                  outValid,
    input  logic                  outReady,
    output logic [IDW-1:0]        outId,
    output fp16_t                 outResult,
    output condCode_t             outCondCodes,
    output opStatusFlag_t         outStatus
`ifdef FPU_ARB_STATS_EN
    ,
    output logic [31:0]           statBusy,
    output logic [31:0]           statStall
`endif
);

    logic            slotFree, anyGrant, opSub;
    logic [NREQ-1:0] pickValid, grant;
    logic [IDW-1:0]  grantIdx, rrPtr;
    fp16_t           opA, opB, dpResult;
    condCode_t       dpCc;
    opStatusFlag_t   dpStatus;

    assign slotFree  = !outValid || outReady;
    assign pickValid = (slotFree && !reset) ? reqValid : '0;

    fpuRRPicker #(.N(NREQ)) uPick (
        .valid (pickValid),
        .ptr   (rrPtr),
        .grant (grant),
        .index (grantIdx)
    );

    assign reqReady = grant;
    assign anyGrant = |grant;
    assign opA      = reqIn1[grantIdx];
    assign opB      = reqIn2[grantIdx];
    assign opSub    = reqSub[grantIdx];

    fpuAddSub16 uDp (
        .in1       (opA),
        .in2       (opB),
        .sub       (opSub),
        .result    (dpResult),
        .condCodes (dpCc),
        .status    (dpStatus)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            outValid     <= 1'b0;
            outId        <= '0;
            outResult    <= '0;
            outCondCodes <= '0;
            outStatus    <= '0;
            rrPtr        <= '0;
        end else if (anyGrant) begin
            outValid     <= 1'b1;
            outId        <= grantIdx;
            outResult    <= dpResult;
            outCondCodes <= dpCc;
            outStatus    <= dpStatus;
            rrPtr        <= (grantIdx == IDW'(NREQ - 1)) ? '0 : grantIdx + 1'b1;
        end else if (outReady) begin
            outValid     <= 1'b0;
        end
    end

`ifdef FPU_ARB_STATS_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            statBusy  <= '0;
            statStall <= '0;
        end else begin
            if (anyGrant && (statBusy != '1))
                statBusy <= statBusy + 32'd1;
            if (!anyGrant && (|reqValid) && (statStall != '1))
                statStall <= statStall + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fpu_addsub_arbiter.sv
// tb/tb_fpu_addsub_arbiter.sv - self-checking bench for fpu_addsub_arbiter
module tb_fpu_addsub_arbiter;
    import fpu_lib::*;

    localparam int NREQ = 4;

    logic                 clock = 1'b0;
    logic                 reset;
    logic [NREQ-1:0]      reqValid, reqReady, reqSub;
    logic [NREQ-1:0][15:0] reqIn1, reqIn2;
    logic                 outValid, outReady;
    logic [1:0]           outId;
    fp16_t                outResult;
    condCode_t            outCondCodes;
    opStatusFlag_t        outStatus;
`ifdef FPU_ARB_STATS_EN
    logic [31:0]          statBusy, statStall;
`endif

    fpu_addsub_arbiter #(.NREQ(NREQ)) dut (
        .clock        (clock),
        .reset        (reset),
        .reqValid     (reqValid),
        .reqReady     (reqReady),
        .reqSub       (reqSub),
        .reqIn1       (reqIn1),
        .reqIn2       (reqIn2),
        .outValid     (outValid),
        .outReady     (outReady),
        .outId        (outId),
        .outResult    (outResult),
        .outCondCodes (outCondCodes),
        .outStatus    (outStatus)
`ifdef FPU_ARB_STATS_EN
        ,
        .statBusy     (statBusy),
        .statStall    (statStall)
`endif
    );

    always #5 clock = ~clock;

    int          nTests = 0;
    int          nFail  = 0;
    int          mPtr;
    logic        mValid;
    int          mId;
    logic [15:0] mRes;
    logic [3:0]  mCc, mSt;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        sub;
        logic [15:0] res;
        logic [3:0]  cc;
        logic [3:0]  st;
    } vec_t;
    vec_t vecs[12];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nTests++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic real fpToReal(input logic [15:0] x);
        real v;
        if (x[14:10] == 5'd0) return 0.0;
        v = $pow(2.0, int'(x[14:10]) - 15) * (1.0 + real'(x[9:0]) / 1024.0);
        return x[15] ? -v : v;
    endfunction

    // Reference: exact real sum, then truncate toward zero into fp16 with flush-to-zero
    task automatic refAdd(input logic [15:0] a, input logic [15:0] b, input logic sub,
                          output logic [15:0] r, output logic [3:0] cc, output logic [3:0] st);
        logic        bs, sg, ovf, unf, inex, carry;
        real         s, mag, frac, mr;
        int          e, be, emax, m;
        bit          aNan, bNan, aInf, bInf;
        bs   = b[15] ^ sub;
        aNan = (a[14:10] == 5'h1f) && (a[9:0] != 0);
        bNan = (b[14:10] == 5'h1f) && (b[9:0] != 0);
        aInf = (a[14:10] == 5'h1f) && (a[9:0] == 0);
        bInf = (b[14:10] == 5'h1f) && (b[9:0] == 0);
        r = 16'h0; ovf = 0; unf = 0; inex = 0; carry = 0;
        if (aNan || bNan || (aInf && bInf && (a[15] != bs))) begin
            r  = 16'h7E00;
            cc = {1'b0, 1'b0, 1'b0, 1'b0};
            st = 4'b1000;
            return;
        end
        if (aInf || bInf) begin
            r  = {aInf ? a[15] : bs, 15'h7C00};
            cc = {1'b0, 1'b0, r[15], 1'b0};
            st = 4'b0000;
            return;
        end
        s    = sub ? fpToReal(a) - fpToReal(b) : fpToReal(a) + fpToReal(b);
        sg   = (s < 0.0);
        mag  = sg ? -s : s;
        emax = (a[14:10] > b[14:10]) ? int'(a[14:10]) : int'(b[14:10]);
        carry = (mag >= $pow(2.0, emax - 15 + 1));
        if (mag != 0.0) begin
            e = 0;
            while (mag >= $pow(2.0, e + 1)) e++;
            while (mag < $pow(2.0, e)) e--;
            be = e + 15;
            if (be >= 31) begin
                r = {sg, 15'h7C00}; ovf = 1; inex = 1;
            end else if (be <= 0) begin
                r = {sg, 15'h0}; unf = 1; inex = 1;
            end else begin
                frac = (mag / $pow(2.0, e) - 1.0) * 1024.0;
                mr   = $floor(frac);
                m    = int'(mr);
                inex = (mr != frac);
                r    = {sg, 5'(be), 10'(m)};
            end
        end
        cc = {(r[14:0] == 15'h0), carry, r[15], ovf};
        st = {1'b0, ovf, unf, inex};
    endtask

    task automatic modelReset();
        mPtr = 0; mValid = 0; mId = 0; mRes = 0; mCc = 0; mSt = 0;
    endtask

    // Called just after inputs are driven on a negedge; returns #1 after the next posedge
    task automatic stepCheck(input string tag);
        int          g;
        logic [15:0] r;
        logic [3:0]  cc, st;
        #1;
        g = -1;
        if (!mValid || outReady)
            for (int k = 0; k < NREQ; k++)
                if (g < 0 && reqValid[(mPtr + k) % NREQ]) g = (mPtr + k) % NREQ;
        check({tag, "/reqReady"}, 64'(reqReady), (g < 0) ? 64'd0 : (64'd1 << g));
        r = 0; cc = 0; st = 0;
        if (g >= 0) refAdd(reqIn1[g], reqIn2[g], reqSub[g], r, cc, st);
        @(posedge clock);
        #1;
        if (g >= 0) begin
            mValid = 1; mId = g; mRes = r; mCc = cc; mSt = st;
            mPtr = (g + 1) % NREQ;
        end else if (outReady) begin
            mValid = 0;
        end
        check({tag, "/outValid"}, 64'(outValid), 64'(mValid));
        if (mValid) begin
            check({tag, "/outId"}, 64'(outId), 64'(mId));
            check({tag, "/outResult"}, 64'(outResult), 64'(mRes));
            check({tag, "/outCondCodes"}, 64'(outCondCodes), 64'(mCc));
            check({tag, "/outStatus"}, 64'(outStatus), 64'(mSt));
        end
    endtask

    task automatic resetDut();
        @(negedge clock);
        reset    = 1'b1;
        reqValid = '1;
        #2;
        check("rst/outValid", 64'(outValid), 64'd0);
        check("rst/reqReady", 64'(reqReady), 64'd0);
        check("rst/outFields", {outId, outResult, outCondCodes, outStatus}, 64'd0);
        @(negedge clock);
        reset    = 1'b0;
        reqValid = '0;
        modelReset();
    endtask

    function automatic logic [15:0] rndOp();
        logic [15:0] v;
        v[15]    = 1'($urandom_range(0, 1));
        v[14:10] = 5'($urandom_range(12, 20));
        v[9:0]   = 10'($urandom);
        return v;
    endfunction

    task automatic rndOperands();
        for (int i = 0; i < NREQ; i++) begin
            reqIn1[i] = rndOp();
            reqIn2[i] = rndOp();
            reqSub[i] = 1'($urandom_range(0, 1));
        end
    endtask

    initial begin
        vecs[0]  = '{16'h3C00, 16'h4000, 1'b0, 16'h4200, 4'b0000, 4'b0000};
        vecs[1]  = '{16'h3C00, 16'h3C00, 1'b0, 16'h4000, 4'b0100, 4'b0000};
        vecs[2]  = '{16'h3C00, 16'h4000, 1'b1, 16'hBC00, 4'b0010, 4'b0000};
        vecs[3]  = '{16'h3C00, 16'h3C00, 1'b1, 16'h0000, 4'b1000, 4'b0000};
        vecs[4]  = '{16'h3C00, 16'h1400, 1'b0, 16'h3C01, 4'b0000, 4'b0000};
        vecs[5]  = '{16'h3C00, 16'h0C00, 1'b0, 16'h3C00, 4'b0000, 4'b0001};
        vecs[6]  = '{16'h3C00, 16'h0C00, 1'b1, 16'h3BFF, 4'b0000, 4'b0001};
        vecs[7]  = '{16'h0401, 16'h0400, 1'b1, 16'h0000, 4'b1000, 4'b0011};
        vecs[8]  = '{16'h7BFF, 16'h7BFF, 1'b0, 16'h7C00, 4'b0101, 4'b0101};
        vecs[9]  = '{16'h7E00, 16'h3C00, 1'b0, 16'h7E00, 4'b0000, 4'b1000};
        vecs[10] = '{16'h7C00, 16'h7C00, 1'b1, 16'h7E00, 4'b0000, 4'b1000};
        vecs[11] = '{16'h7C00, 16'h3C00, 1'b0, 16'h7C00, 4'b0000, 4'b0000};

        reset    = 1'b1;
        reqValid = '0;
        reqSub   = '0;
        reqIn1   = '0;
        reqIn2   = '0;
        outReady = 1'b1;
        modelReset();
        resetDut();

        // 1.0 + 2.0 from requester 0
        @(negedge clock);
        reqValid = 4'b0001; reqIn1[0] = 16'h3C00; reqIn2[0] = 16'h4000; reqSub[0] = 1'b0;
        outReady = 1'b1;
        stepCheck("t1");
        check("t1/outValid", 64'(outValid), 64'd1);
        check("t1/outResult", 64'(outResult), 64'h4200);
        check("t1/outId", 64'(outId), 64'd0);
        check("t1/nz", {outCondCodes.n, outCondCodes.z}, 64'd0);

        // requester 2 subtracts equal values
        @(negedge clock);
        reqValid = 4'b0100; reqIn1[2] = 16'h3C00; reqIn2[2] = 16'h3C00; reqSub[2] = 1'b1;
        stepCheck("t2");
        check("t2/outResult", 64'(outResult), 64'h0000);
        check("t2/z", 64'(outCondCodes.z), 64'd1);
        check("t2/outId", 64'(outId), 64'd2);

        for (int i = 0; i < 12; i++) begin
            @(negedge clock);
            reqValid = 4'b0001;
            reqIn1[0] = vecs[i].a; reqIn2[0] = vecs[i].b; reqSub[0] = vecs[i].sub;
            stepCheck($sformatf("vec%0d", i));
            check($sformatf("vec%0d/res", i), 64'(outResult), 64'(vecs[i].res));
            check($sformatf("vec%0d/cc", i), 64'(outCondCodes), 64'(vecs[i].cc));
            check($sformatf("vec%0d/st", i), 64'(outStatus), 64'(vecs[i].st));
        end

        // all requesters valid: strict rotation from 0
        resetDut();
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            reqValid = '1; outReady = 1'b1;
            rndOperands();
            stepCheck("t3");
            check("t3/rotation", 64'(outId), 64'(i % NREQ));
        end

        // back-pressure holds the slot, release grants in the same cycle
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            reqValid = '1; outReady = 1'b0;
            rndOperands();
            stepCheck("t4");
            check("t4/held", {63'd0, outValid}, 64'd1);
        end
        @(negedge clock);
        outReady = 1'b1;
        #1;
        check("t4/releaseGrant", 64'(reqReady), 64'b0001);
        stepCheck("t4r");

        // reset while full
        @(negedge clock);
        reqValid = '1; outReady = 1'b0;
        stepCheck("t5fill");
        @(negedge clock);
        #3;
        reset = 1'b1;
        #1;
        check("t5/outValid", 64'(outValid), 64'd0);
        check("t5/reqReady", 64'(reqReady), 64'd0);
        @(negedge clock);
        reset = 1'b0;
        modelReset();
        outReady = 1'b1;
        reqValid = '1;
        #1;
        check("t5/firstGrant", 64'(reqReady), 64'b0001);
        stepCheck("t5");
        check("t5/outId", 64'(outId), 64'd0);

`ifdef FPU_ARB_STATS_EN
        resetDut();
        for (int i = 0; i < 13; i++) begin
            @(negedge clock);
            reqValid = 4'b0001;
            outReady = (i < 10);
            stepCheck("t6");
        end
        @(negedge clock);
        reqValid = '0;
        #1;
        check("t6/statBusy", 64'(statBusy), 64'd10);
        check("t6/statStall", 64'(statStall), 64'd3);
`endif

        for (int i = 0; i < 300; i++) begin
            @(negedge clock);
            reqValid = 4'($urandom);
            outReady = ($urandom_range(0, 3) != 0);
            rndOperands();
            stepCheck("rnd");
        end

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
